// File: rtl/iterative_alu.sv
// iterative_alu: RV-style integer ALU; single-cycle ops plus an optional
// iterative MUL/DIV/REM unit enabled by macro ITERATIVE_ALU_MULDIV_EN.
// Ports: clk, reset (async, active high), instruction (funct7/funct3),
//   alu_op, data_1, data_2, start -> busy, done, data_out, illegal.
module iterative_alu #(
  parameter int INSTRUCTION_LEN = 32,
  parameter int N = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INSTRUCTION_LEN-1:0] instruction,
  input  logic [1:0]                 alu_op,
  input  logic [N-1:0]               data_1,
  input  logic [N-1:0]               data_2,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [N-1:0]               data_out,
  output logic                       illegal
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_DIV,
    OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_e;

`ifdef ITERATIVE_ALU_MULDIV_EN
  typedef enum logic [1:0] {
    IDLE, CALC, FIN
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE, FIN
  } state_e;
`endif

  state_e         state_q;
  state_e         state_d;
  op_e            op;
  logic [6:0]     funct7;
  logic [2:0]     funct3;
  logic [SW-1:0]  shamt;
  logic [N-1:0]   res;
  logic           accept;
  logic           unused_instr;

  assign funct7       = instruction[31:25];
  assign funct3       = instruction[14:12];
  assign unused_instr = ^instruction;
  assign shamt        = data_2[SW-1:0];
  assign accept       = (state_q == IDLE) && start;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);

  always_comb begin
    op = OP_ILL;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  op = OP_ADD;
              3'b111:  op = OP_AND;
              3'b110:  op = OP_OR;
              3'b100:  op = OP_XOR;
              3'b001:  op = OP_SLL;
              3'b101:  op = OP_SRL;
              3'b010:  op = OP_SLT;
              default: op = OP_SLTU;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000:  op = OP_SUB;
              3'b101:  op = OP_SRA;
              default: op = OP_ILL;
            endcase
          end
`ifdef ITERATIVE_ALU_MULDIV_EN
          7'b0000001: begin
            case (funct3)
              3'b000:  op = OP_MUL;
              3'b100:  op = OP_DIV;
              3'b101:  op = OP_DIVU;
              3'b110:  op = OP_REM;
              3'b111:  op = OP_REMU;
              default: op = OP_ILL;
            endcase
          end
`endif
          default: op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = data_1 + data_2;
      OP_SUB:  res = data_1 - data_2;
      OP_AND:  res = data_1 & data_2;
      OP_OR:   res = data_1 | data_2;
      OP_XOR:  res = data_1 ^ data_2;
      OP_SLL:  res = data_1 << shamt;
      OP_SRL:  res = data_1 >> shamt;
      OP_SRA:  res = $signed(data_1) >>> shamt;
      OP_SLT:  res = {{(N-1){1'b0}},
                      $signed(data_1) < $signed(data_2)};
      OP_SLTU: res = {{(N-1){1'b0}},
                      data_1 < data_2};
      default: res = '0;
    endcase
  end

`ifdef ITERATIVE_ALU_MULDIV_EN
  // acc_q: product / partial remainder
  // opa_q: multiplicand / dividend-quotient shift register
  // opb_q: multiplier / divisor magnitude
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  acc_q;
  logic [N-1:0]  opa_q;
  logic [N-1:0]  opb_q;
  logic [N-1:0]  save_q;
  logic          mul_q;
  logic          rem_q;
  logic          negq_q;
  logic          negr_q;
  logic          dz_q;
  logic          multi;
  logic          sgn;
  logic          s1;
  logic          s2;
  logic [N:0]    trial;
  logic          ge;
  logic [N-1:0]  acc_d;
  logic [N-1:0]  opa_d;
  logic [N-1:0]  md_res;

  assign multi = (op == OP_MUL) || (op == OP_DIV) ||
                 (op == OP_DIVU) || (op == OP_REM) ||
                 (op == OP_REMU);
  assign sgn = (op == OP_DIV) || (op == OP_REM);
  assign s1  = sgn & data_1[N-1];
  assign s2  = sgn & data_2[N-1];

  always_comb begin
    trial = {acc_q, opa_q[N-1]};
    ge    = trial >= {1'b0, opb_q};
    acc_d = acc_q;
    opa_d = opa_q;
    if (mul_q) begin
      acc_d = opb_q[0] ? acc_q + opa_q : acc_q;
      opa_d = opa_q << 1;
    end else begin
      acc_d = ge ? N'(trial - {1'b0, opb_q})
                 : trial[N-1:0];
      opa_d = {opa_q[N-2:0], ge};
    end
  end

  // Divide-by-zero is patched at the end so the
  // datapath never needs a special case per step.
  always_comb begin
    md_res = acc_d;
    if (!mul_q) begin
      if (rem_q)
        md_res = dz_q   ? save_q :
                 negr_q ? -acc_d : acc_d;
      else
        md_res = dz_q   ? {N{1'b1}} :
                 negq_q ? -opa_d : opa_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ITERATIVE_ALU_MULDIV_EN
          state_d = multi ? CALC : FIN;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef ITERATIVE_ALU_MULDIV_EN
      CALC: begin
        if (cnt_q == CW'(1)) state_d = FIN;
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      illegal  <= 1'b0;
`ifdef ITERATIVE_ALU_MULDIV_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      save_q   <= '0;
      mul_q    <= 1'b0;
      rem_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
`ifdef ITERATIVE_ALU_MULDIV_EN
        if (multi) begin
          cnt_q  <= CW'(N);
          acc_q  <= '0;
          opa_q  <= s1 ? -data_1 : data_1;
          opb_q  <= s2 ? -data_2 : data_2;
          save_q <= data_1;
          mul_q  <= (op == OP_MUL);
          rem_q  <= (op == OP_REM) ||
                    (op == OP_REMU);
          negq_q <= s1 ^ s2;
          negr_q <= s1;
          dz_q   <= (data_2 == '0);
        end else begin
          data_out <= res;
          illegal  <= (op == OP_ILL);
        end
`else
        data_out <= res;
        illegal  <= (op == OP_ILL);
`endif
      end
`ifdef ITERATIVE_ALU_MULDIV_EN
      if (state_q == CALC) begin
        cnt_q <= cnt_q - CW'(1);
        acc_q <= acc_d;
        opa_q <= opa_d;
        if (mul_q) opb_q <= opb_q >> 1;
        if (cnt_q == CW'(1)) begin
          data_out <= md_res;
          illegal  <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed vectors against a behavioural ALU model,
// one compare process checking busy/done/data_out/illegal every cycle.
module tb_iterative_alu;
  localparam int N = 64;
`ifdef ITERATIVE_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam logic [N-1:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [N-1:0] ONES = {N{1'b1}};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  instruction;
  logic [1:0]   alu_op;
  logic [N-1:0] data_1;
  logic [N-1:0] data_2;
  logic         start;
  logic         busy;
  logic         done;
  logic [N-1:0] data_out;
  logic         illegal;

  always #5 clk = ~clk;

  iterative_alu #(.INSTRUCTION_LEN(32), .N(N)) dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .alu_op(alu_op),
    .data_1(data_1),
    .data_2(data_2),
    .start(start),
    .busy(busy),
    .done(done),
    .data_out(data_out),
    .illegal(illegal)
  );

  typedef struct {
    int           acc;
    int           due;
    logic [N-1:0] data;
    logic         ill;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic [N-1:0] last_data = '0;
  logic         last_ill = 1'b0;

  task automatic chk(input string name,
                     input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ins(input logic [6:0] f7,
                                      input logic [2:0] f3);
    return {f7, 10'd0, f3, 12'd0};
  endfunction

  function automatic logic [N:0] model(input logic [1:0] aop,
                                       input logic [31:0] iw,
                                       input logic [N-1:0] a,
                                       input logic [N-1:0] b);
    logic [6:0] f7;
    logic [2:0] f3;
    int         sh;
    longint     sa;
    longint     sb;
    logic       dz;
    logic       ovf;
    f7  = iw[31:25];
    f3  = iw[14:12];
    sh  = int'(b[5:0]);
    sa  = a;
    sb  = b;
    dz  = (b == '0);
    ovf = (a == MIN) && (b == ONES);
    if (aop == 2'b00) return {1'b0, a + b};
    if (aop == 2'b01) return {1'b0, a - b};
    if (aop == 2'b11) return {1'b1, 64'd0};
    if (f7 == 7'h00) begin
      case (f3)
        3'd0: return {1'b0, a + b};
        3'd7: return {1'b0, a & b};
        3'd6: return {1'b0, a | b};
        3'd4: return {1'b0, a ^ b};
        3'd1: return {1'b0, a << sh};
        3'd5: return {1'b0, a >> sh};
        3'd2: return {1'b0, 63'd0, sa < sb};
        default: return {1'b0, 63'd0, a < b};
      endcase
    end
    if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, a - b};
    if (f7 == 7'h20 && f3 == 3'd5) return {1'b0, 64'(sa >>> sh)};
    if (f7 == 7'h01 && MD) begin
      case (f3)
        3'd0: return {1'b0, 64'(a * b)};
        3'd4: return {1'b0, dz ? ONES : ovf ? a : 64'(sa / sb)};
        3'd5: return {1'b0, dz ? ONES : a / b};
        3'd6: return {1'b0, dz ? a : ovf ? 64'd0 : 64'(sa % sb)};
        3'd7: return {1'b0, dz ? a : a % b};
        default: return {1'b1, 64'd0};
      endcase
    end
    return {1'b1, 64'd0};
  endfunction

  function automatic bit multi(input logic [1:0] aop,
                               input logic [31:0] iw);
    logic [2:0] f3;
    f3 = iw[14:12];
    return MD && aop == 2'b10 && iw[31:25] == 7'h01 &&
           (f3 == 3'd0 || f3 >= 3'd4);
  endfunction

  task automatic wait_q();
    int i = 0;
    while (q.size() > 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d ops pending, want 0", q.size());
      q.delete();
    end
  endtask

  // hold: extra cycles start stays high (with junk operands)
  // after acceptance; all of them must be ignored.
  task automatic issue(input logic [1:0] aop,
                       input logic [31:0] iw,
                       input logic [N-1:0] a,
                       input logic [N-1:0] b,
                       input int hold,
                       input bit wt);
    exp_t       e;
    logic [N:0] m;
    @(negedge clk);
    alu_op      = aop;
    instruction = iw;
    data_1      = a;
    data_2      = b;
    start       = 1'b1;
    m     = model(aop, iw, a, b);
    e.acc = cyc + 1;
    e.due = cyc + 1 + (multi(aop, iw) ? N : 0);
    e.data = m[N-1:0];
    e.ill  = m[N];
    q.push_back(e);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      alu_op      = 2'b10;
      instruction = ins(7'h00, 3'd0);
      data_1      = {$urandom, $urandom};
      data_2      = {$urandom, $urandom};
    end
    @(negedge clk);
    start = 1'b0;
    if (wt) wait_q();
  endtask

  initial begin
    bit eb;
    bit ed;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      eb = (q.size() > 0) && (cyc >= q[0].acc);
      ed = (q.size() > 0) && (cyc == q[0].due);
      if (ed) begin
        last_data = q[0].data;
        last_ill  = q[0].ill;
        void'(q.pop_front());
      end
      chk("busy", N'(busy), N'(eb));
      chk("done", N'(done), N'(ed));
      chk("data_out", data_out, last_data);
      chk("illegal", N'(illegal), N'(last_ill));
    end
  end

  initial begin
    start       = 1'b0;
    alu_op      = 2'b00;
    instruction = '0;
    data_1      = '0;
    data_2      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", N'(busy), '0);
    chk("rst_data", data_out, '0);
    reset = 1'b0;

    issue(2'b10, ins(7'h00, 3'd0), 64'd5, 64'd7, 0, 1);
    chk("lit_add", data_out, 64'd12);
    chk("lit_add_ill", N'(illegal), '0);
    issue(2'b00, '0, ONES, 64'd1, 0, 1);
    chk("lit_wrap_add", data_out, '0);
    issue(2'b01, '0, 64'd0, 64'd1, 0, 1);
    chk("lit_wrap_sub", data_out, ONES);
    issue(2'b10, ins(7'h00, 3'd7), 64'hF0F0, 64'hFF00, 0, 1);
    issue(2'b10, ins(7'h00, 3'd6), 64'hF0F0, 64'hFF00, 0, 1);
    issue(2'b10, ins(7'h00, 3'd4), 64'hF0F0, 64'hFF00, 0, 1);
    issue(2'b10, ins(7'h00, 3'd1), 64'd1, 64'd63, 0, 1);
    issue(2'b10, ins(7'h00, 3'd5), MIN, 64'd68, 0, 1);
    issue(2'b10, ins(7'h20, 3'd5), MIN, 64'd4, 0, 1);
    chk("lit_sra", data_out, 64'hF800_0000_0000_0000);
    issue(2'b10, ins(7'h00, 3'd2), ONES, 64'd1, 0, 1);
    chk("lit_slt", data_out, 64'd1);
    issue(2'b10, ins(7'h00, 3'd3), ONES, 64'd1, 0, 1);
    chk("lit_sltu", data_out, 64'd0);
    issue(2'b10, ins(7'h20, 3'd0), 64'd3, 64'd10, 0, 1);
    issue(2'b11, '0, 64'd3, 64'd4, 0, 1);
    chk("lit_illegal", N'(illegal), N'(1'b1));
    chk("lit_illegal_data", data_out, '0);
    issue(2'b10, ins(7'h20, 3'd1), 64'd3, 64'd4, 0, 1);
    issue(2'b10, ins(7'h00, 3'd0), 64'd100, 64'd23, 1, 1);

    issue(2'b10, ins(7'h01, 3'd0), ONES, 64'd3, MD ? 40 : 1, 1);
    chk("lit_mul", data_out, MD ? 64'hFFFF_FFFF_FFFF_FFFD : '0);
    issue(2'b10, ins(7'h01, 3'd4), -64'd7, 64'd2, 0, 1);
    chk("lit_div", data_out, MD ? -64'd3 : '0);
    issue(2'b10, ins(7'h01, 3'd6), -64'd7, 64'd2, 0, 1);
    chk("lit_rem", data_out, MD ? ONES : '0);
    issue(2'b10, ins(7'h01, 3'd5), 64'd7, 64'd0, 0, 1);
    chk("lit_divu0", data_out, MD ? ONES : '0);
    issue(2'b10, ins(7'h01, 3'd6), 64'd7, 64'd0, 0, 1);
    chk("lit_rem0", data_out, MD ? 64'd7 : '0);
    issue(2'b10, ins(7'h01, 3'd4), MIN, ONES, 0, 1);
    chk("lit_div_ovf", data_out, MD ? MIN : '0);
    chk("lit_div_ovf_ill", N'(illegal), MD ? '0 : N'(1'b1));
    issue(2'b10, ins(7'h01, 3'd6), MIN, ONES, 0, 1);
    issue(2'b10, ins(7'h01, 3'd4), -64'd9, 64'd0, 0, 1);
    issue(2'b10, ins(7'h01, 3'd7), 64'd100, 64'd7, 0, 1);
    issue(2'b10, ins(7'h01, 3'd5), ONES, 64'd10, 0, 1);
    issue(2'b10, ins(7'h01, 3'd4), 64'd1000, -64'd7, 0, 1);
    issue(2'b10, ins(7'h01, 3'd6), 64'd1000, -64'd7, 0, 1);
    issue(2'b10, ins(7'h01, 3'd0), 64'h1234_5678_9ABC_DEF0,
          64'h0FED_CBA9_8765_4321, 0, 1);
    issue(2'b10, ins(7'h01, 3'd1), 64'd3, 64'd4, 0, 1);

    issue(2'b10, ins(7'h01, 3'd4), 64'd1000, 64'd3, 0, 0);
    repeat (28) @(negedge clk);
    reset = 1'b1;
    q.delete();
    last_data = '0;
    last_ill  = 1'b0;
    #1;
    chk("rst_async_busy", N'(busy), '0);
    chk("rst_async_done", N'(done), '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    issue(2'b00, '0, 64'd40, 64'd2, 0, 1);
    chk("lit_after_rst", data_out, 64'd42);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
